// File: rtl/mbist_op_sel.sv
// MBIST operation selector: walks the valid slots of one march element,
// issuing read/write operations and pulsing address advance / element completion.
module mbist_op_sel #(
    parameter int BIST_OP_SIZE = 4,
    parameter int BIST_STI_WD  = 1 + 3 * BIST_OP_SIZE,
    localparam int IDX_W       = (BIST_OP_SIZE > 1) ? $clog2(BIST_OP_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [BIST_STI_WD-1:0] stimulus,
    input  logic                   last_stimulus,
    input  logic                   last_addr,
    input  logic                   mem_ready,
    output logic                   op_valid,
    output logic                   op_write,
    output logic                   op_invert,
    output logic                   op_reverse,
    output logic [IDX_W-1:0]       op_idx,
    output logic                   last_op,
    output logic                   addr_inc,
    output logic                   sti_done,
    output logic                   bist_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_op_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    r_bist_done;

    logic [BIST_OP_SIZE-1:0] w_slot_valid;
    logic [BIST_OP_SIZE-1:0] w_slot_write;
    logic [BIST_OP_SIZE-1:0] w_slot_invert;
    logic [IDX_W-1:0]        w_first_idx;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_any_valid;
    logic                    w_has_next;
    logic                    w_last_op;
    logic                    w_addr_inc;
    logic                    w_sti_done;

    // Slot decode plus search for the lowest valid slot and the next valid slot above op_idx.
    // NOTE: every variable gets a default before the loops so no latch is inferred.
    always_comb begin
        w_first_idx = '0;
        w_next_idx  = '0;
        w_has_next  = 1'b0;
        for (int k = 0; k < BIST_OP_SIZE; k++) begin
            w_slot_valid[k]  = stimulus[3*k+2];
            w_slot_write[k]  = stimulus[3*k+1];
            w_slot_invert[k] = stimulus[3*k];
        end
        w_any_valid = |w_slot_valid;
        for (int k = BIST_OP_SIZE - 1; k >= 0; k--) begin
            if (w_slot_valid[k]) begin
                w_first_idx = IDX_W'(k);
                if (k > int'(r_op_idx)) begin
                    w_has_next = 1'b1;
                    w_next_idx = IDX_W'(k);
                end
            end
        end
    end

    assign w_last_op  = w_slot_valid[r_op_idx] & ~w_has_next;
    // A run abort suppresses the address advance even while an op is on the bus.
    assign w_addr_inc = (r_state == S_EXEC) & run & mem_ready & w_last_op;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_op_idx;
        w_sti_done  = 1'b0;
        if (!run) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_idx_nxt = '0;
                    if (!r_bist_done) begin
                        if (w_any_valid) begin
                            w_state_nxt = S_EXEC;
                            w_idx_nxt   = w_first_idx;
                        end else begin
                            w_sti_done  = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    if (mem_ready) begin
                        if (!w_last_op) begin
                            w_idx_nxt = w_next_idx;
                        end else if (last_addr) begin
                            w_sti_done  = 1'b1;
                            w_state_nxt = S_DONE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = w_first_idx;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_idx    <= '0;
            r_bist_done <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op_idx <= w_idx_nxt;
            if (!run) begin
                r_bist_done <= 1'b0;
            end else if (w_sti_done && last_stimulus) begin
                r_bist_done <= 1'b1;
            end
        end
    end

    assign op_valid   = (r_state == S_EXEC);
    assign op_write   = w_slot_write[r_op_idx];
    assign op_invert  = w_slot_invert[r_op_idx];
    assign op_reverse = stimulus[BIST_STI_WD-1];
    assign op_idx     = r_op_idx;
    assign last_op    = w_last_op;
    assign addr_inc   = w_addr_inc;
    assign sti_done   = w_sti_done;
    assign bist_done  = r_bist_done;

endmodule

// File: tb/tb_mbist_op_sel.sv
// Scoreboard bench for mbist_op_sel: the driver queues hand-computed operations,
// a negedge monitor pops and compares them whenever op_valid is high.
module tb_mbist_op_sel;

    logic        clk;
    logic        rst;
    logic        run;
    logic [12:0] stimulus;
    logic        last_stimulus;
    logic        last_addr;
    logic        mem_ready;
    logic        op_valid;
    logic        op_write;
    logic        op_invert;
    logic        op_reverse;
    logic [1:0]  op_idx;
    logic        last_op;
    logic        addr_inc;
    logic        sti_done;
    logic        bist_done;

    typedef struct packed {
        logic [1:0] idx;
        logic       wr;
        logic       inv;
        logic       rev;
        logic       last;
        logic       ainc;
        logic       sdone;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;
    int   idle_sdone_cnt;
    int   sdone_base;

    mbist_op_sel dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .stimulus     (stimulus),
        .last_stimulus(last_stimulus),
        .last_addr    (last_addr),
        .mem_ready    (mem_ready),
        .op_valid     (op_valid),
        .op_write     (op_write),
        .op_invert    (op_invert),
        .op_reverse   (op_reverse),
        .op_idx       (op_idx),
        .last_op      (last_op),
        .addr_inc     (addr_inc),
        .sti_done     (sti_done),
        .bist_done    (bist_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic wr, input logic inv, input logic rev,
                        input logic last, input logic ainc, input logic sdone);
        exp_t e;
        e.idx   = idx;
        e.wr    = wr;
        e.inv   = inv;
        e.rev   = rev;
        e.last  = last;
        e.ainc  = ainc;
        e.sdone = sdone;
        sb_q.push_back(e);
    endtask

    // Monitor: compares each presented operation against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (op_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_op: got op_idx %0d, expected no operation (t=%0t)", op_idx, $time);
            end else begin
                e = sb_q.pop_front();
                check("op_idx",     32'(op_idx),     32'(e.idx));
                check("op_write",   32'(op_write),   32'(e.wr));
                check("op_invert",  32'(op_invert),  32'(e.inv));
                check("op_reverse", 32'(op_reverse), 32'(e.rev));
                check("last_op",    32'(last_op),    32'(e.last));
                check("addr_inc",   32'(addr_inc),   32'(e.ainc));
                check("sti_done",   32'(sti_done),   32'(e.sdone));
            end
        end else if (sti_done === 1'b1) begin
            idle_sdone_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        idle_sdone_cnt = 0;
        rst            = 1'b1;
        run            = 1'b0;
        stimulus       = '0;
        last_stimulus  = 1'b0;
        last_addr      = 1'b0;
        mem_ready      = 1'b1;
        repeat (2) tick();

        check("rst_op_valid",  32'(op_valid),  0);
        check("rst_op_idx",    32'(op_idx),    0);
        check("rst_addr_inc",  32'(addr_inc),  0);
        check("rst_sti_done",  32'(sti_done),  0);
        check("rst_bist_done", 32'(bist_done), 0);

        // Up element W0,R0,W1: two addresses, the second is last.
        rst      = 1'b0;
        stimulus = 13'h11E6;
        for (int a = 0; a < 2; a++) begin
            push(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            push(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            push(2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, (a == 1) ? 1'b1 : 1'b0);
        end
        run = 1'b1;
        #1;
        check("idle_no_sdone", 32'(sti_done), 0);
        repeat (4) tick();
        last_addr = 1'b1;
        repeat (3) tick();
        check("done_op_valid", 32'(op_valid), 0);
        check("done_sti_done", 32'(sti_done), 0);
        last_addr = 1'b0;
        tick();
        check("idle_op_valid", 32'(op_valid), 0);

        // Restart at slot 0, stall three cycles on slot 1, then a run abort on slot 2.
        push(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) push(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        mem_ready = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        tick();
        check("abort_op_valid", 32'(op_valid), 0);
        check("abort_op_idx",   32'(op_idx),   0);
        check("abort_sti_done", 32'(sti_done), 0);

        // Restart, then synchronous reset while slot 2 is presented.
        run = 1'b1;
        push(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        rst       = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("rst_mid_op_valid",  32'(op_valid),  0);
        check("rst_mid_op_idx",    32'(op_idx),    0);
        check("rst_mid_bist_done", 32'(bist_done), 0);
        rst       = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        tick();

        // Element with no valid slot: completes from IDLE every other cycle.
        stimulus   = 13'h0000;
        sdone_base = idle_sdone_cnt;
        run        = 1'b1;
        #1;
        check("empty_sti_done", 32'(sti_done), 1);
        check("empty_op_valid", 32'(op_valid), 0);
        repeat (6) tick();
        check("empty_sdone_count", 32'(idle_sdone_cnt - sdone_base), 3);
        run = 1'b0;
        repeat (2) tick();

        // Single valid slot (slot 1, read inverted, down), final stimulus sets bist_done.
        stimulus = 13'h0028;
        push(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        push(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        push(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run = 1'b1;
        repeat (3) tick();
        last_addr     = 1'b1;
        last_stimulus = 1'b1;
        tick();
        check("bist_done_set", 32'(bist_done), 1);
        last_addr = 1'b0;
        repeat (2) tick();
        check("bist_done_hold", 32'(bist_done), 1);
        check("bist_done_no_op", 32'(op_valid), 0);
        run = 1'b0;
        tick();
        check("bist_done_clear", 32'(bist_done), 0);
        last_stimulus = 1'b0;

        tick();
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
